// File: rtl/mem_stage_if.sv
// Data-cache <-> memory-controller request bus: line fill and dirty-line eviction.
interface mem_stage_if #(
    parameter int unsigned MADDR_W   = 26,
    parameter int unsigned LINE_BITS = 128
);
    logic                 mem_req;
    logic                 mem_is_write;
    logic [MADDR_W-1:0]   mem_addr;
    logic [LINE_BITS-1:0] mem_wdata;
    logic [LINE_BITS-1:0] mem_rdata;
    logic                 mem_rdata_rdy;
    logic                 mem_wr_ack;

    modport master (
        output mem_req, mem_is_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_rdata_rdy, mem_wr_ack
    );

    modport slave (
        input  mem_req, mem_is_write, mem_addr, mem_wdata,
        output mem_rdata, mem_rdata_rdy, mem_wr_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: direct-mapped write-back/write-allocate data cache with
// miss FSM (evict dirty victim, then fill) and registered write-back latch.
module mem_stage #(
    parameter int unsigned LINES     = 4,
    parameter int unsigned LINE_BITS = 128,
    parameter int unsigned MADDR_W   = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wrt_en,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  regD_in,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        MEM_TO_REG,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_regD,
    output logic        wb_en,
    output logic        block_pipe_data_cache,
    mem_stage_if.master mem
);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
    localparam int unsigned WSEL_W = $clog2(LINE_BITS / 32);
    localparam int unsigned TAG_W  = MADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, EVICT, FILL} state_t;

    state_t state, next_state;

    logic [LINE_BITS-1:0] lines [LINES];
    logic [TAG_W-1:0]     tags  [LINES];
    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;

    logic                 req_q, req_d;
    logic                 is_write_q, is_write_d;
    logic [MADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic                 fill_done, evict_done;

    // Address decode of the current access
    logic [MADDR_W-1:0]   line_addr;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [WSEL_W-1:0]    wsel;
    logic [LINE_BITS-1:0] line_sel;
    logic [31:0]          word;
    logic                 unused_addr_bits;

    assign line_addr        = alu_result[OFF_W+MADDR_W-1:OFF_W];
    assign idx              = line_addr[IDX_W-1:0];
    assign tag              = line_addr[MADDR_W-1:IDX_W];
    assign wsel             = alu_result[OFF_W-1:2];
    assign line_sel         = lines[idx];
    assign word             = line_sel[{wsel, 5'b0} +: 32];
    assign unused_addr_bits = ^{alu_result[31:OFF_W+MADDR_W], alu_result[1:0]};

    logic mem_op, hit, miss, store_commit;

    assign mem_op       = MEM_R_EN | MEM_W_EN;
    assign hit          = valid[idx] & (tags[idx] == tag);
    assign miss         = (state == IDLE) & mem_op & ~hit;
    assign block_pipe_data_cache = (state != IDLE) | miss;
    assign store_commit = wrt_en & ~block_pipe_data_cache & MEM_W_EN;

    assign mem.mem_req      = req_q;
    assign mem.mem_is_write = is_write_q;
    assign mem.mem_addr     = addr_q;
    assign mem.mem_wdata    = wdata_q;

    // Miss FSM: next state and next bus request
    always_comb begin
        next_state = state;
        req_d      = req_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fill_done  = 1'b0;
        evict_done = 1'b0;
        case (state)
            IDLE: begin
                if (miss) begin
                    req_d = 1'b1;
                    if (valid[idx] & dirty[idx]) begin
                        next_state = EVICT;
                        is_write_d = 1'b1;
                        addr_d     = {tags[idx], idx};
                        wdata_d    = line_sel;
                    end else begin
                        next_state = FILL;
                        is_write_d = 1'b0;
                        addr_d     = line_addr;
                    end
                end
            end
            EVICT: begin
                if (mem.mem_wr_ack) begin
                    evict_done = 1'b1;
                    next_state = FILL;
                    is_write_d = 1'b0;
                    addr_d     = line_addr;
                end
            end
            FILL: begin
                if (mem.mem_rdata_rdy) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                    req_d      = 1'b0;
                    is_write_d = 1'b0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control state, line status bits and write-back latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            valid      <= '0;
            dirty      <= '0;
            wb_data    <= '0;
            wb_regD    <= '0;
            wb_en      <= 1'b0;
        end else begin
            state      <= next_state;
            req_q      <= req_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if (fill_done) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (evict_done) dirty[idx] <= 1'b0;
            if (store_commit) dirty[idx] <= 1'b1;
            if (wrt_en) begin
                if (block_pipe_data_cache) begin
                    wb_en <= 1'b0;
                end else begin
                    wb_data <= MEM_TO_REG ? word : alu_result;
                    wb_regD <= regD_in;
                    wb_en   <= WB_EN_in;
                end
            end
        end
    end

    // Line data and tags; status bits alone decide validity, so no reset here
    always_ff @(posedge clk) begin
        if (fill_done && !reset) begin
            lines[idx] <= mem.mem_rdata;
            tags[idx]  <= tag;
        end else if (store_commit) begin
            lines[idx][{wsel, 5'b0} +: 32] <= store_data;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: fills, hits, eviction, stalls, reset mid-miss.
module tb_mem_stage;
    logic        clk;
    logic        reset;
    logic        wrt_en;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  regD_in;
    logic        WB_EN_in;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        MEM_TO_REG;
    logic [31:0] wb_data;
    logic [4:0]  wb_regD;
    logic        wb_en;
    logic        block_pipe_data_cache;

    mem_stage_if bus ();

    mem_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .wrt_en                (wrt_en),
        .alu_result            (alu_result),
        .store_data            (store_data),
        .regD_in               (regD_in),
        .WB_EN_in              (WB_EN_in),
        .MEM_R_EN              (MEM_R_EN),
        .MEM_W_EN              (MEM_W_EN),
        .MEM_TO_REG            (MEM_TO_REG),
        .wb_data               (wb_data),
        .wb_regD               (wb_regD),
        .wb_en                 (wb_en),
        .block_pipe_data_cache (block_pipe_data_cache),
        .mem                   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [127:0] LINE1 = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_1000};
    localparam logic [127:0] LINE5 = {32'h5555_0053, 32'h5555_0052, 32'h5555_0051, 32'h5555_0050};
    localparam logic [127:0] LINEX = {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
    localparam logic [127:0] EVICTED = {32'h3333_0003, 32'h2222_0002, 32'hDEAD_BEEF, 32'h0000_1000};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd, input logic wben);
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        MEM_TO_REG = r;
        alu_result = a;
        store_data = sd;
        regD_in    = rd;
        WB_EN_in   = wben;
    endtask

    initial begin
        reset = 1'b1;
        wrt_en = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        bus.mem_rdata = '0;
        bus.mem_rdata_rdy = 1'b0;
        bus.mem_wr_ack = 1'b0;
        tick();
        tick();
        check("rst_wb_data", 128'(wb_data), 128'h0);
        check("rst_wb_regD", 128'(wb_regD), 128'h0);
        check("rst_wb_en", 128'(wb_en), 128'h0);
        check("rst_req", 128'(bus.mem_req), 128'h0);
        check("rst_is_write", 128'(bus.mem_is_write), 128'h0);
        check("rst_addr", 128'(bus.mem_addr), 128'h0);
        check("rst_wdata", bus.mem_wdata, 128'h0);
        check("rst_block", 128'(block_pipe_data_cache), 128'h0);
        reset = 1'b0;

        // Cold load miss on line 1, then fill
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd3, 1'b1);
        #1;
        check("cold_block", 128'(block_pipe_data_cache), 128'h1);
        check("cold_req_pre", 128'(bus.mem_req), 128'h0);
        tick();
        check("fill_req", 128'(bus.mem_req), 128'h1);
        check("fill_is_write", 128'(bus.mem_is_write), 128'h0);
        check("fill_addr", 128'(bus.mem_addr), 128'h1);
        check("fill_wb_en_bubble", 128'(wb_en), 128'h0);
        tick();
        check("fill_req_hold", 128'(bus.mem_req), 128'h1);
        bus.mem_rdata = LINE1;
        bus.mem_rdata_rdy = 1'b1;
        tick();
        bus.mem_rdata_rdy = 1'b0;
        check("fill_req_drop", 128'(bus.mem_req), 128'h0);
        check("fill_hit_block", 128'(block_pipe_data_cache), 128'h0);
        tick();
        check("hit_w0", 128'(wb_data), 128'h0000_1000);
        check("hit_w0_en", 128'(wb_en), 128'h1);
        check("hit_w0_regD", 128'(wb_regD), 128'd3);

        // Store hit, then read it back
        drive(1'b0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 5'd0, 1'b0);
        #1;
        check("st_block", 128'(block_pipe_data_cache), 128'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0014, 32'h0, 5'd5, 1'b1);
        #1;
        check("ld14_block", 128'(block_pipe_data_cache), 128'h0);
        check("ld14_req", 128'(bus.mem_req), 128'h0);
        tick();
        check("ld14_data", 128'(wb_data), 128'hDEAD_BEEF);
        check("ld14_regD", 128'(wb_regD), 128'd5);
        drive(1'b1, 1'b0, 32'h0000_001C, 32'h0, 5'd6, 1'b1);
        tick();
        check("ld1c_data", 128'(wb_data), 128'h3333_0003);

        // Conflict miss on dirty line 1: evict then fill line 5
        drive(1'b1, 1'b0, 32'h0000_0050, 32'h0, 5'd8, 1'b1);
        #1;
        check("ev_block", 128'(block_pipe_data_cache), 128'h1);
        tick();
        check("ev_req", 128'(bus.mem_req), 128'h1);
        check("ev_is_write", 128'(bus.mem_is_write), 128'h1);
        check("ev_addr", 128'(bus.mem_addr), 128'h1);
        check("ev_wdata", bus.mem_wdata, EVICTED);
        bus.mem_wr_ack = 1'b1;
        tick();
        bus.mem_wr_ack = 1'b0;
        check("ev_fill_is_write", 128'(bus.mem_is_write), 128'h0);
        check("ev_fill_addr", 128'(bus.mem_addr), 128'h5);
        check("ev_fill_req", 128'(bus.mem_req), 128'h1);
        check("ev_fill_block", 128'(block_pipe_data_cache), 128'h1);
        bus.mem_rdata = LINE5;
        bus.mem_rdata_rdy = 1'b1;
        tick();
        bus.mem_rdata_rdy = 1'b0;
        check("ev_done_block", 128'(block_pipe_data_cache), 128'h0);
        tick();
        check("ld50_data", 128'(wb_data), 128'h5555_0050);

        // Stalled store commits exactly once when enabled
        drive(1'b0, 1'b0, 32'h0000_AAAA, 32'h0, 5'd0, 1'b0);
        tick();
        check("bub_wb_en", 128'(wb_en), 128'h0);
        check("bub_wb_data", 128'(wb_data), 128'h0000_AAAA);
        wrt_en = 1'b0;
        drive(1'b0, 1'b1, 32'h0000_0058, 32'hCAFE_F00D, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_wb_en", 128'(wb_en), 128'h0);
            check("stall_wb_data", 128'(wb_data), 128'h0000_AAAA);
        end
        wrt_en = 1'b1;
        tick();
        // A stalled store that is withdrawn must leave the line untouched
        wrt_en = 1'b0;
        drive(1'b0, 1'b1, 32'h0000_005C, 32'hBADB_AD00, 5'd0, 1'b0);
        tick();
        tick();
        wrt_en = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0058, 32'h0, 5'd9, 1'b1);
        tick();
        check("ld58_data", 128'(wb_data), 128'hCAFE_F00D);
        drive(1'b1, 1'b0, 32'h0000_005C, 32'h0, 5'd9, 1'b1);
        tick();
        check("ld5c_data", 128'(wb_data), 128'h5555_0053);

        // Plain ALU op passes through
        drive(1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd7, 1'b1);
        #1;
        check("alu_block", 128'(block_pipe_data_cache), 128'h0);
        tick();
        check("alu_data", 128'(wb_data), 128'h0000_1234);
        check("alu_regD", 128'(wb_regD), 128'd7);
        check("alu_en", 128'(wb_en), 128'h1);

        // Reset during FILL aborts the miss without writing the line
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd10, 1'b1);
        tick();
        check("r_ev_is_write", 128'(bus.mem_is_write), 128'h1);
        check("r_ev_addr", 128'(bus.mem_addr), 128'h5);
        bus.mem_wr_ack = 1'b1;
        tick();
        bus.mem_wr_ack = 1'b0;
        check("r_fill_addr", 128'(bus.mem_addr), 128'h1);
        reset = 1'b1;
        bus.mem_rdata = LINEX;
        bus.mem_rdata_rdy = 1'b1;
        tick();
        bus.mem_rdata_rdy = 1'b0;
        reset = 1'b0;
        check("r_req_drop", 128'(bus.mem_req), 128'h0);
        check("r_wb_en", 128'(wb_en), 128'h0);
        check("r_remiss_block", 128'(block_pipe_data_cache), 128'h1);
        tick();
        check("r_refill_req", 128'(bus.mem_req), 128'h1);
        check("r_refill_is_write", 128'(bus.mem_is_write), 128'h0);
        check("r_refill_addr", 128'(bus.mem_addr), 128'h1);
        bus.mem_rdata = LINE1;
        bus.mem_rdata_rdy = 1'b1;
        tick();
        bus.mem_rdata_rdy = 1'b0;
        tick();
        check("r_refill_data", 128'(wb_data), 128'h0000_1000);
        check("r_refill_regD", 128'(wb_regD), 128'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
